wb_manager: RTL
===============

WB_MANAGER -- requirements
Module: wb_manager

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, bus cycles waited for m_ack_i before abort (legal 1..65535).
REQ-002 SHALL have port: wb_clk_i  input  1  sole clock, all logic rising-edge.
REQ-003 SHALL have port: wb_rst_i  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req_valid  input  1  request offered.
REQ-005 SHALL have port: req_ready  output  1  block can accept request.
REQ-006 SHALL have port: req_we  input  1  1=write, 0=read.
REQ-007 SHALL have port: req_adr  input  32  byte address.
REQ-008 SHALL have port: req_dat  input  32  write data.
REQ-009 SHALL have port: req_sel  input  4  byte lane select.
REQ-010 SHALL have port: rsp_valid  output  1  response available.
REQ-011 SHALL have port: rsp_ready  input  1  consumer takes response.
REQ-012 SHALL have port: rsp_dat  output  32  read data (0 for writes and errors).
REQ-013 SHALL have port: rsp_err  output  1  transfer aborted by timeout.
REQ-014 SHALL have ports: m_cyc_o, m_stb_o, m_we_o  output  1 each  Wishbone initiator controls.
REQ-015 SHALL have ports: m_sel_o output 4, m_adr_o output 32, m_dat_o output 32  Wishbone initiator select/address/data.
REQ-016 SHALL have ports: m_dat_i input 32, m_ack_i input 1  Wishbone responder data/acknowledge.
REQ-017 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, BUS, RESP; req_ready = (state==IDLE).
REQ-019 IDLE: on req_valid&&req_ready SHALL register we/adr/dat/sel onto m_*_o, clear timeout counter, go BUS.
REQ-020 BUS: m_cyc_o=m_stb_o=1; m_we_o/m_sel_o/m_adr_o/m_dat_o SHALL stay stable for the whole state.
REQ-021 BUS with m_ack_i=1: same edge SHALL deassert cyc/stb, latch rsp_dat=m_dat_i for reads (0 for writes), rsp_err=0, go RESP.
REQ-022 Minimum latency: request accepted edge N, stb high cycle N+1, ack in N+1 gives rsp_valid in cycle N+2.
REQ-023 RESP: rsp_valid=1, rsp_dat/rsp_err held stable until rsp_valid&&rsp_ready, then IDLE; next request is accepted no earlier than the following cycle.
REQ-024 m_ack_i outside BUS SHALL be ignored; cyc and stb SHALL always be equal.
REQ-025 Single transfers only, no pipelining; at most one outstanding request.

Reset
REQ-026 wb_rst_i high at an edge SHALL force IDLE; m_cyc_o, m_stb_o, m_we_o, rsp_valid, rsp_err, busy = 0; m_sel_o, m_adr_o, m_dat_o, rsp_dat = 0; req_ready = 1 from the first cycle after reset.
REQ-027 Reset mid-BUS or mid-RESP SHALL drop cyc/stb and discard the transfer with no response.

Configuration
REQ-028 Macro WB_MANAGER_TIMEOUT_EN defined: a 16-bit counter increments each BUS cycle without ack; when it reaches TIMEOUT_CYCLES, same edge SHALL drop cyc/stb, set rsp_err=1, rsp_dat=0, go RESP.
REQ-029 Ack in the same cycle the timeout is reached SHALL win: normal response, rsp_err=0.
REQ-030 Macro undefined: no counter logic, BUS waits indefinitely, rsp_err tied 0.

Verification
REQ-031 Read: req adr=0x3000_0004, responder acks 1 cycle after stb with 0xDEAD_BEEF -> rsp_valid with rsp_dat=0xDEAD_BEEF, rsp_err=0, cyc high exactly 2 cycles.
REQ-032 Write: adr=0x3000_0000, dat=0x1234_5678, sel=0xF, immediate ack -> m_we_o=1, m_dat_o stable while stb, rsp_dat=0, rsp_valid at N+2.
REQ-033 Backpressure: rsp_ready low 5 cycles with req_valid held -> req_ready=0, response held stable, second request accepted only after the handshake.
REQ-034 Timeout (macro on, TIMEOUT_CYCLES=4): no ack -> stb high 4 cycles, rsp_err=1, rsp_dat=0; ack in cycle 4 -> rsp_err=0.
REQ-035 wb_rst_i pulsed during BUS -> cyc/stb low next cycle, no rsp_valid, next request completes normally.

Source files
------------

// File: rtl/wb_manager.sv
// wb_manager: single-transfer Wishbone initiator behind a valid/ready request/response handshake.
// Define WB_MANAGER_TIMEOUT_EN to abort a transfer that sees no ack within TIMEOUT_CYCLES bus cycles.
module wb_manager #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_dat,
    input  logic [3:0]  req_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
    state_t state, state_nxt;
    logic timeout;
    logic done;

`ifdef WB_MANAGER_TIMEOUT_EN
    logic [15:0] cnt;
    // Fires on the cycle the count would reach the limit, so stb stays up exactly TIMEOUT_CYCLES cycles.
    assign timeout = !m_ack_i && (cnt == 16'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || state != BUS)
            cnt <= '0;
        else
            cnt <= cnt + 16'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    assign done      = (state == BUS) && (m_ack_i || timeout);
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign m_cyc_o   = (state == BUS);
    assign m_stb_o   = (state == BUS);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = req_valid ? BUS : IDLE;
            BUS:     state_nxt = (m_ack_i || timeout) ? RESP : BUS;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            m_we_o  <= 1'b0;
            m_sel_o <= '0;
            m_adr_o <= '0;
            m_dat_o <= '0;
            rsp_dat <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                m_we_o  <= req_we;
                m_sel_o <= req_sel;
                m_adr_o <= req_adr;
                m_dat_o <= req_dat;
            end
            if (done) begin
                rsp_dat <= (m_ack_i && !m_we_o) ? m_dat_i : 32'h0;
                rsp_err <= timeout;
            end
        end
    end
endmodule
